// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target receiver: FSM states and bus-level constants.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ACK_A,
    DATA,
    ACK_D,
    IGNORE
  } state_t;

  localparam logic I2C_ACK      = 1'b0;
  localparam logic I2C_NACK     = 1'b1;
  localparam logic I2C_RW_WRITE = 1'b0;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchroniser plus edge detector for one asynchronous bus line (SCL or SDA).
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic line_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // Idle bus lines float high, so reset to 1 to avoid a false edge on release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '1;
      hist_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], line_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~hist_q;
  assign fall  = ~level & hist_q;

endmodule

// File: rtl/i2c_slave_rx.sv
// Write-only I2C target: detects START/STOP, matches the address, ACKs and
// delivers each received data byte to core logic. Only ever pulls SDA low.
module i2c_slave_rx
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h1A,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       addr_match,
  output logic       busy,
  output logic       stop_det
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
    .clk(clk), .rst(rst), .line_in(scl_in),
    .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
    .clk(clk), .rst(rst), .line_in(sda_in),
    .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
  );

  state_t     state_q, state_nxt;
  logic [2:0] cnt_q, cnt_nxt;
  logic       full_q, full_nxt;
  logic [7:0] shift_q, shift_nxt;
  logic [7:0] rx_data_nxt;
  logic       sda_oe_nxt, rx_valid_nxt, addr_match_nxt, busy_nxt, stop_det_nxt;
  logic       start_c, stop_c;

  assign start_c = sda_fall & scl_lvl;
  assign stop_c  = sda_rise & scl_lvl;

  // full_q marks that all 8 bits of the current byte are in; the counter alone wraps to 0.
  always_comb begin
    state_nxt      = state_q;
    cnt_nxt        = cnt_q;
    full_nxt       = full_q;
    shift_nxt      = shift_q;
    rx_data_nxt    = rx_data;
    sda_oe_nxt     = sda_oe;
    rx_valid_nxt   = 1'b0;
    addr_match_nxt = addr_match;
    busy_nxt       = busy;
    stop_det_nxt   = 1'b0;

    if (stop_c) begin
      state_nxt      = IDLE;
      sda_oe_nxt     = 1'b0;
      busy_nxt       = 1'b0;
      stop_det_nxt   = 1'b1;
      addr_match_nxt = 1'b0;
    end else if (start_c) begin
      state_nxt      = ADDR;
      cnt_nxt        = 3'd0;
      full_nxt       = 1'b0;
      busy_nxt       = 1'b1;
      addr_match_nxt = 1'b0;
      sda_oe_nxt     = 1'b0;
    end else begin
      case (state_q)
        ADDR, DATA: begin
          if (scl_rise && !full_q) begin
            shift_nxt = {shift_q[6:0], sda_lvl};
            cnt_nxt   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) full_nxt = 1'b1;
          end else if (scl_fall && full_q) begin
            if (state_q == ADDR) begin
              if (shift_q[7:1] == SLAVE_ADDR && shift_q[0] == I2C_RW_WRITE) begin
                sda_oe_nxt     = 1'b1;
                addr_match_nxt = 1'b1;
                state_nxt      = ACK_A;
              end else begin
                state_nxt = IGNORE;
              end
            end else begin
              rx_data_nxt  = shift_q;
              rx_valid_nxt = 1'b1;
              sda_oe_nxt   = 1'b1;
              state_nxt    = ACK_D;
            end
          end
        end
        ACK_A, ACK_D: begin
          if (scl_fall) begin
            sda_oe_nxt = 1'b0;
            cnt_nxt    = 3'd0;
            full_nxt   = 1'b0;
            state_nxt  = DATA;
          end
        end
        IGNORE:  sda_oe_nxt = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      full_q     <= 1'b0;
      shift_q    <= 8'h00;
      rx_data    <= 8'h00;
      sda_oe     <= 1'b0;
      rx_valid   <= 1'b0;
      addr_match <= 1'b0;
      busy       <= 1'b0;
      stop_det   <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      cnt_q      <= cnt_nxt;
      full_q     <= full_nxt;
      shift_q    <= shift_nxt;
      rx_data    <= rx_data_nxt;
      sda_oe     <= sda_oe_nxt;
      rx_valid   <= rx_valid_nxt;
      addr_match <= addr_match_nxt;
      busy       <= busy_nxt;
      stop_det   <= stop_det_nxt;
    end
  end

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Bench for i2c_slave_rx: open-drain bus model, SCL = clk/16, table vectors,
// hand-written corner sequences and randomized transfers against a transfer-level model.
module tb_i2c_slave_rx;
  import i2c_pkg::*;

  localparam logic [6:0] SLAVE_ADDR = 7'h1A;
  localparam logic [7:0] ADDR_W     = {SLAVE_ADDR, I2C_RW_WRITE};

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_m, sda_m;
  logic       sda_bus;
  logic       sda_oe, rx_valid, addr_match, busy, stop_det;
  logic [7:0] rx_data;

  assign sda_bus = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave_rx #(.SLAVE_ADDR(SLAVE_ADDR), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .scl_in(scl_m), .sda_in(sda_bus),
    .sda_oe(sda_oe), .rx_data(rx_data), .rx_valid(rx_valid),
    .addr_match(addr_match), .busy(busy), .stop_det(stop_det)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0] rx_q[$];
  int         stop_cnt = 0;
  int         oe_cnt   = 0;

  always @(negedge clk) begin
    if (rx_valid) rx_q.push_back(rx_data);
    if (stop_det) stop_cnt++;
    if (sda_oe)   oe_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, output logic seen);
    sda_m = b;  tick(4);
    scl_m = 1'b1; tick(4);
    seen = sda_bus; tick(4);
    scl_m = 1'b0; tick(4);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic [7:0] echo, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i], echo[i]);
    send_bit(1'b1, ack);
  endtask

  task automatic send_bits(input logic [7:0] d, input int k);
    logic s;
    for (int i = 7; i > 7 - k; i--) send_bit(d[i], s);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; tick(4);
    scl_m = 1'b1; tick(4);
    sda_m = 1'b0; tick(4);
    scl_m = 1'b0; tick(4);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; tick(4);
    scl_m = 1'b1; tick(4);
    sda_m = 1'b1; tick(8);
  endtask

  typedef struct {
    string            name;
    logic [7:0]       addr;
    int               n;
    logic [2:0][7:0]  d;
    logic             exp_aack;
    logic             exp_dack;
    logic             exp_match;
    int               exp_nrx;
  } vec_t;

  vec_t vecs[4];

  task automatic apply_vec(input vec_t v);
    int         rx_mark, stop_mark, oe_mark;
    logic [7:0] echo;
    logic       ack;
    rx_mark   = rx_q.size();
    stop_mark = stop_cnt;
    oe_mark   = oe_cnt;
    bus_start();
    check({v.name, "_busy"}, busy, 1'b1);
    send_byte(v.addr, echo, ack);
    check({v.name, "_addr_echo"}, echo, v.addr);
    check({v.name, "_addr_ack"}, ack, v.exp_aack);
    check({v.name, "_addr_match"}, addr_match, v.exp_match);
    for (int j = 0; j < v.n; j++) begin
      send_byte(v.d[j], echo, ack);
      check($sformatf("%s_d%0d_echo", v.name, j), echo, v.d[j]);
      check($sformatf("%s_d%0d_ack", v.name, j), ack, v.exp_dack);
    end
    bus_stop();
    check({v.name, "_busy_after_stop"}, busy, 1'b0);
    check({v.name, "_match_after_stop"}, addr_match, 1'b0);
    check({v.name, "_stop_det"}, stop_cnt - stop_mark, 1);
    check({v.name, "_oe_used"}, (oe_cnt - oe_mark) != 0, v.exp_match);
    check({v.name, "_rx_count"}, rx_q.size() - rx_mark, v.exp_nrx);
    if (rx_q.size() - rx_mark == v.exp_nrx)
      for (int j = 0; j < v.exp_nrx; j++)
        check($sformatf("%s_rx%0d", v.name, j), rx_q[rx_mark + j], v.d[j]);
  endtask

  initial begin
    int         rx_mark, stop_mark;
    logic [7:0] echo, addr, d;
    logic       ack, match, s;
    logic [7:0] exp_q[$];

    vecs[0] = '{"w55",   8'h34, 1, {8'h00, 8'h00, 8'h55}, I2C_ACK,  I2C_ACK,  1'b1, 1};
    vecs[1] = '{"badad", 8'h36, 1, {8'h00, 8'h00, 8'hFF}, I2C_NACK, I2C_NACK, 1'b0, 0};
    vecs[2] = '{"read",  8'h35, 1, {8'h00, 8'h00, 8'h5A}, I2C_NACK, I2C_NACK, 1'b0, 0};
    vecs[3] = '{"two",   8'h34, 2, {8'h00, 8'h3C, 8'hA5}, I2C_ACK,  I2C_ACK,  1'b1, 2};

    rst = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
    tick(4);
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_addr_match", addr_match, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_stop_det", stop_det, 1'b0);
    rst = 1'b1;
    tick(4);

    for (int i = 0; i < 4; i++) apply_vec(vecs[i]);

    // Partial byte then repeated START: only the complete byte after it is delivered.
    rx_mark = rx_q.size(); stop_mark = stop_cnt;
    bus_start();
    send_byte(ADDR_W, echo, ack);
    check("rs_addr_ack", ack, I2C_ACK);
    send_bits(8'hB0, 4);
    bus_start();
    check("rs_match_cleared", addr_match, 1'b0);
    check("rs_no_partial", rx_q.size() - rx_mark, 0);
    send_byte(ADDR_W, echo, ack);
    check("rs_addr2_ack", ack, I2C_ACK);
    send_byte(8'h81, echo, ack);
    check("rs_data_ack", ack, I2C_ACK);
    bus_stop();
    check("rs_rx_count", rx_q.size() - rx_mark, 1);
    if (rx_q.size() - rx_mark == 1) check("rs_rx_byte", rx_q[rx_mark], 8'h81);
    check("rs_stop_det", stop_cnt - stop_mark, 1);

    // Reset asserted mid-ACK must drop sda_oe without waiting for a clock edge.
    bus_start();
    for (int i = 7; i >= 0; i--) send_bit(ADDR_W[i], s);
    sda_m = 1'b1; tick(4);
    scl_m = 1'b1; tick(2);
    check("ack_oe_before_rst", sda_oe, 1'b1);
    #1 rst = 1'b0;
    #1 check("rst_async_oe", sda_oe, 1'b0);
    tick(2);
    check("rst_mid_match", addr_match, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_rx_valid", rx_valid, 1'b0);
    check("rst_mid_stop_det", stop_det, 1'b0);
    check("rst_mid_rx_data", rx_data, 8'h00);
    scl_m = 1'b0; tick(2);
    sda_m = 1'b0; tick(2);
    scl_m = 1'b1; tick(2);
    sda_m = 1'b1; tick(4);
    rst = 1'b1;
    tick(4);
    apply_vec(vecs[0]);

    // Randomized transfers, optionally split by a partial byte and a repeated START.
    for (int t = 0; t < 20; t++) begin
      int nseg;
      rx_mark = rx_q.size(); stop_mark = stop_cnt;
      exp_q.delete();
      nseg = $urandom_range(1, 2);
      bus_start();
      for (int sg = 0; sg < nseg; sg++) begin
        int n;
        addr  = ($urandom_range(0, 1) == 1) ? ADDR_W : 8'($urandom_range(0, 255));
        match = (addr == ADDR_W);
        send_byte(addr, echo, ack);
        check($sformatf("rnd%0d_addr_ack", t), ack, match ? I2C_ACK : I2C_NACK);
        n = $urandom_range(0, 3);
        for (int j = 0; j < n; j++) begin
          d = 8'($urandom_range(0, 255));
          send_byte(d, echo, ack);
          check($sformatf("rnd%0d_echo", t), echo, d);
          check($sformatf("rnd%0d_data_ack", t), ack, match ? I2C_ACK : I2C_NACK);
          if (match) exp_q.push_back(d);
        end
        if (sg < nseg - 1) begin
          send_bits(8'($urandom_range(0, 255)), $urandom_range(0, 7));
          bus_start();
        end
      end
      bus_stop();
      check($sformatf("rnd%0d_stop_det", t), stop_cnt - stop_mark, 1);
      check($sformatf("rnd%0d_rx_count", t), rx_q.size() - rx_mark, exp_q.size());
      if (rx_q.size() - rx_mark == exp_q.size())
        foreach (exp_q[j]) check($sformatf("rnd%0d_rx%0d", t, j), rx_q[rx_mark + j], exp_q[j]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
